// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with synchronised, optionally debounced
// inputs, byte-lane writable OUT/OE/RISE_EN/FALL_EN and a w1c STATUS register.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   address_in          - bus address, register index in bits [4:2]
//   sel_in, read_in     - block select, read strobe (reads have no side effects)
//   write_mask_in       - byte-lane write enables, write_value_in - write data
//   read_value_out      - read data (0 when not selected), ready_out = sel_in
//   gpio_in             - asynchronous pin inputs
//   gpio_out, gpio_oe_out - pin drive values and per-pin output enables
//   irq_out             - level interrupt, OR of STATUS
module gpio_bank #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe_out,
    output logic             irq_out
);

    localparam logic [2:0] IDX_OUT    = 3'd0;
    localparam logic [2:0] IDX_OE     = 3'd1;
    localparam logic [2:0] IDX_IN     = 3'd2;
    localparam logic [2:0] IDX_RISE   = 3'd3;
    localparam logic [2:0] IDX_FALL   = 3'd4;
    localparam logic [2:0] IDX_STATUS = 3'd5;

    logic [2:0]       idx;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] status_q;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] in_next;

    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c_clr;

    logic unused_bits;

    assign idx       = address_in[4:2];
    assign lane_mask = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                        {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
    assign wmask     = lane_mask[WIDTH-1:0];
    assign wdata     = write_value_in[WIDTH-1:0];

    assign unused_bits = ^{address_in, read_in, write_value_in, lane_mask};

    // Input synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            // IN is the last synchroniser stage; the stage before it is
            // what IN will hold after the next edge.
            assign in_val  = synced;
            assign in_next = sync_q[SYNC_STAGES-2];
        end else begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0] in_q;
            logic [CW-1:0]    cnt_q [WIDTH];

            assign in_val = in_q;

            // A bit flips when its counter is about to reach DEBOUNCE_CYCLES
            always_comb begin
                in_next = in_q;
                for (int i = 0; i < WIDTH; i++) begin
                    if (synced[i] != in_q[i] && cnt_q[i] == CNT_LAST) begin
                        in_next[i] = synced[i];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    in_q <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    in_q <= in_next;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (synced[i] == in_q[i] || cnt_q[i] == CNT_LAST) begin
                            cnt_q[i] <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CW'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    // Edges are flagged on the same edge that IN itself changes
    assign edge_set = (in_next & ~in_val & rise_q) |
                      (~in_next & in_val & fall_q);

    assign w1c_clr = (sel_in && idx == IDX_STATUS) ? (wdata & wmask) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            oe_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
        end else begin
            if (sel_in && idx == IDX_OUT) begin
                out_q <= (out_q & ~wmask) | (wdata & wmask);
            end
            if (sel_in && idx == IDX_OE) begin
                oe_q <= (oe_q & ~wmask) | (wdata & wmask);
            end
            if (sel_in && idx == IDX_RISE) begin
                rise_q <= (rise_q & ~wmask) | (wdata & wmask);
            end
            if (sel_in && idx == IDX_FALL) begin
                fall_q <= (fall_q & ~wmask) | (wdata & wmask);
            end
            // New edges win over a simultaneous clear
            status_q <= (status_q & ~w1c_clr) | edge_set;
        end
    end

    always_comb begin
        read_value_out = '0;
        if (sel_in) begin
            case (idx)
                IDX_OUT:    read_value_out = 32'(out_q);
                IDX_OE:     read_value_out = 32'(oe_q);
                IDX_IN:     read_value_out = 32'(in_val);
                IDX_RISE:   read_value_out = 32'(rise_q);
                IDX_FALL:   read_value_out = 32'(fall_q);
                IDX_STATUS: read_value_out = 32'(status_q);
                default:    read_value_out = '0;
            endcase
        end
    end

    assign ready_out   = sel_in;
    assign gpio_out    = out_q;
    assign gpio_oe_out = oe_q;
    assign irq_out     = |status_q;

endmodule
